// File: rtl/huffman_codec.sv
// huffman_codec: Huffman encoder/decoder streaming bytes from an 8-bit scratchpad.
// Encode packs codes MSB-first into bytes; decode walks canonical per-length tables one bit per cycle.
module huffman_codec (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_encoding,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic [31:0] io_req_bits_head,
    input  logic [31:0] io_req_bits_length,
    output logic        io_sp_read_en,
    output logic [15:0] io_sp_read_addr,
    input  logic [7:0]  io_sp_read_data,
    output logic        io_resp_valid,
    output logic [7:0]  io_resp_bits,
    input  logic        io_write_en,
    input  logic        io_write_order_table,
    input  logic [7:0]  io_write_addr,
    input  logic [63:0] io_write_data,
    input  logic        io_csr_write,
    input  logic [1:0]  io_csr_addr,
    input  logic [10:0] io_csr_data
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    logic [20:0] code_tab [256];
    logic [63:0] sym_tab [32];
    logic [15:0] first_tab [16];
    logic [8:0]  count_tab [16];
    logic [7:0]  base_tab [16];
    logic [10:0] csr_q [4];

    state_t      state_q, state_d;
    logic        enc_q, enc_d, rd_en_q, rd_en_d, pend_q, vld_q, vld_d, ready_q, ready_d, go;
    logic [15:0] ptr_q, ptr_d, rd_addr_q, rd_addr_d, code_q, code_d;
    logic [31:0] left_q, left_d;
    logic [23:0] acc_q, acc_d;
    logic [4:0]  acnt_q, acnt_d, dlen_q, dlen_d;
    logic [7:0]  buf_q, buf_d, byte_q, byte_d;
    logic [3:0]  bcnt_q, bcnt_d;

    logic [20:0] ent;
    logic [4:0]  elen, ecnt;
    logic [15:0] ecode;
    logic        emit;
    assign ent   = code_tab[io_sp_read_data];
    assign elen  = ent[20:16];
    assign ecode = ent[15:0] & (16'hffff >> (5'd16 - elen));
    assign emit  = acnt_q >= 5'd8;
    assign ecnt  = emit ? acnt_q - 5'd8 : acnt_q;

    // Decode consumes the freshly read byte directly in the cycle it arrives.
    logic [7:0]  src, rank;
    logic [3:0]  src_n, lidx;
    logic [15:0] code_n, diff;
    logic [4:0]  len_n;
    logic [63:0] sword;
    logic        take, hit;
    assign src    = pend_q ? io_sp_read_data : buf_q;
    assign src_n  = pend_q ? 4'd8 : bcnt_q;
    assign take   = state_q == RUN && !enc_q && left_q != 32'd0 && src_n != 4'd0;
    assign code_n = {code_q[14:0], src[7]};
    assign len_n  = dlen_q + 5'd1;
    assign lidx   = len_n[3:0] - 4'd1;
    assign diff   = code_n - first_tab[lidx];
    assign hit    = diff < {7'd0, count_tab[lidx]};
    assign rank   = base_tab[lidx] + diff[7:0];
    assign sword  = sym_tab[rank[7:3]];

    always_comb begin
        state_d = state_q; enc_d = enc_q; ptr_d = ptr_q; left_d = left_q;
        acc_d = acc_q; acnt_d = acnt_q; buf_d = buf_q; bcnt_d = bcnt_q;
        code_d = code_q; dlen_d = dlen_q; byte_d = byte_q; rd_addr_d = rd_addr_q;
        rd_en_d = 1'b0; vld_d = 1'b0; go = 1'b0;
        case (state_q)
            IDLE: if (io_req_valid) begin
                state_d = RUN; enc_d = io_encoding; ptr_d = io_req_bits_head[15:0];
                left_d = io_req_bits_length; acnt_d = '0; bcnt_d = '0; code_d = '0; dlen_d = '0;
            end
            RUN: if (enc_q) begin
                if (emit) begin vld_d = 1'b1; byte_d = 8'(acc_q >> (acnt_q - 5'd8)); end
                acnt_d = pend_q ? ecnt + elen : ecnt;
                if (pend_q) acc_d = (acc_q << elen) | 24'(ecode);
                // Reads alternate with appends so at most one byte ever backs up in the accumulator.
                if (left_q != 32'd0 && !rd_en_q) begin go = 1'b1; left_d = left_q - 32'd1; end
                else if (left_q == 32'd0 && !rd_en_q && !pend_q && !emit) state_d = acnt_q == 5'd0 ? IDLE : FLUSH;
            end else if (left_q == 32'd0) state_d = IDLE;
            else begin
                if (take) begin
                    buf_d = {src[6:0], 1'b0}; bcnt_d = src_n - 4'd1;
                    code_d = hit || len_n == 5'd16 ? '0 : code_n;
                    dlen_d = hit || len_n == 5'd16 ? '0 : len_n;
                    if (hit) begin vld_d = 1'b1; byte_d = sword[{rank[2:0], 3'b000} +: 8]; left_d = left_q - 32'd1; end
                end
                go = left_d != 32'd0 && (bcnt_d == 4'd1 || (bcnt_d == 4'd0 && !rd_en_q && !pend_q));
            end
            FLUSH: if (acnt_q != 5'd0) begin
                vld_d = 1'b1; byte_d = 8'(acc_q << (5'd8 - acnt_q)); acnt_d = '0;
            end else state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (go) begin rd_en_d = 1'b1; rd_addr_d = ptr_q; ptr_d = ptr_q + 16'd1; end
        ready_d = state_d == IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE; enc_q <= 1'b0; ptr_q <= '0; left_q <= '0; acc_q <= '0; acnt_q <= '0;
            buf_q <= '0; bcnt_q <= '0; code_q <= '0; dlen_q <= '0; byte_q <= '0; rd_addr_q <= '0;
            rd_en_q <= 1'b0; pend_q <= 1'b0; vld_q <= 1'b0; ready_q <= 1'b1;
            for (int i = 0; i < 4; i++) csr_q[i] <= '0;
        end else begin
            state_q <= state_d; enc_q <= enc_d; ptr_q <= ptr_d; left_q <= left_d; acc_q <= acc_d; acnt_q <= acnt_d;
            buf_q <= buf_d; bcnt_q <= bcnt_d; code_q <= code_d; dlen_q <= dlen_d; byte_q <= byte_d; rd_addr_q <= rd_addr_d;
            rd_en_q <= rd_en_d; pend_q <= rd_en_q; vld_q <= vld_d; ready_q <= ready_d;
            if (io_csr_write) csr_q[io_csr_addr] <= io_csr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (io_write_en && !io_write_order_table) code_tab[io_write_addr] <= io_write_data[20:0];
        if (io_write_en && io_write_order_table && io_write_addr[7:5] == 3'd0) sym_tab[io_write_addr[4:0]] <= io_write_data;
        if (io_write_en && io_write_order_table && io_write_addr[7:4] == 4'd2) begin
            first_tab[io_write_addr[3:0]] <= io_write_data[15:0];
            count_tab[io_write_addr[3:0]] <= io_write_data[24:16];
            base_tab[io_write_addr[3:0]] <= io_write_data[39:32];
        end
    end

    logic unused_ok;
    assign unused_ok = ^{io_req_bits_head[31:16], code_q[15], csr_q[0], csr_q[1], csr_q[2], csr_q[3]};

    assign io_req_ready    = ready_q;
    assign io_sp_read_en   = rd_en_q;
    assign io_sp_read_addr = rd_addr_q;
    assign io_resp_valid   = vld_q;
    assign io_resp_bits    = byte_q;
endmodule

// File: tb/tb_huffman_codec.sv
// tb_huffman_codec: scoreboard bench for huffman_codec with a behavioural scratchpad.
// Expected bytes are queued at issue; a negedge monitor pops and compares each output pulse.
module tb_huffman_codec;
    logic        clock = 1'b0, reset = 1'b1;
    logic        io_encoding = 1'b0, io_req_valid = 1'b0, io_req_ready;
    logic [31:0] io_req_bits_head = '0, io_req_bits_length = '0;
    logic        io_sp_read_en;
    logic [15:0] io_sp_read_addr;
    logic [7:0]  io_sp_read_data = '0;
    logic        io_resp_valid;
    logic [7:0]  io_resp_bits;
    logic        io_write_en = 1'b0, io_write_order_table = 1'b0;
    logic [7:0]  io_write_addr = '0;
    logic [63:0] io_write_data = '0;
    logic        io_csr_write = 1'b0;
    logic [1:0]  io_csr_addr = '0;
    logic [10:0] io_csr_data = '0;

    always #5 clock = ~clock;

    huffman_codec dut (
        .clock(clock), .reset(reset), .io_encoding(io_encoding),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
        .io_req_bits_head(io_req_bits_head), .io_req_bits_length(io_req_bits_length),
        .io_sp_read_en(io_sp_read_en), .io_sp_read_addr(io_sp_read_addr), .io_sp_read_data(io_sp_read_data),
        .io_resp_valid(io_resp_valid), .io_resp_bits(io_resp_bits),
        .io_write_en(io_write_en), .io_write_order_table(io_write_order_table),
        .io_write_addr(io_write_addr), .io_write_data(io_write_data),
        .io_csr_write(io_csr_write), .io_csr_addr(io_csr_addr), .io_csr_data(io_csr_data)
    );

    logic [7:0] mem [65536];
    always @(posedge clock) if (io_sp_read_en) io_sp_read_data <= mem[io_sp_read_addr];

    int compared = 0, mismatched = 0, resp_count = 0, rd_count = 0;
    logic [7:0] exp_q [$];

    always @(negedge clock) begin
        if (!reset && io_sp_read_en) rd_count++;
        if (!reset && io_resp_valid) begin
            resp_count++;
            compared++;
            if (io_req_ready) begin
                mismatched++;
                $display("FAIL ready_with_valid: io_req_ready=%0b while io_resp_valid=1, want 0", io_req_ready);
            end
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL resp: got %02h, want no output", io_resp_bits);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (io_resp_bits !== e) begin
                    mismatched++;
                    $display("FAIL resp: got %02h, want %02h", io_resp_bits, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    task automatic wr_table(input logic ord, input logic [7:0] a, input logic [63:0] d);
        io_write_en = 1'b1; io_write_order_table = ord; io_write_addr = a; io_write_data = d;
        @(negedge clock);
        io_write_en = 1'b0;
    endtask

    task automatic wr_csr(input logic [1:0] a, input logic [10:0] d);
        io_csr_write = 1'b1; io_csr_addr = a; io_csr_data = d;
        @(negedge clock);
        io_csr_write = 1'b0;
    endtask

    task automatic request(input logic enc, input logic [15:0] head, input int len);
        io_encoding = enc; io_req_bits_head = {16'd0, head}; io_req_bits_length = 32'(len); io_req_valid = 1'b1;
        @(negedge clock);
        io_req_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget, output int n);
        n = 0;
        while (!io_req_ready && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({nm, "_done"}, 64'(io_req_ready), 64'd1);
        repeat (2) @(negedge clock);
    endtask

    task automatic run_abc(input string tag);
        int n;
        exp_q.push_back(8'h58);
        request(1'b1, 16'h0000, 4);
        wait_done({tag, "_enc"}, 50, n);
        check({tag, "_enc_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h41);
        request(1'b0, 16'h0010, 4);
        wait_done({tag, "_dec"}, 50, n);
        check({tag, "_dec_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    int          rlen [256];
    int          tlen [256];
    logic [15:0] tcode [256];
    logic [7:0]  rsym [256];
    logic [7:0]  src [1000];
    logic        bits [$];
    logic [7:0]  enc [$];
    logic [63:0] wd;
    logic [7:0]  by, x;
    int          code, rank, n, rc0, rs0;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_ready", 64'(io_req_ready), 64'd1);
        check("rst_valid", 64'(io_resp_valid), 64'd0);
        check("rst_bits", 64'(io_resp_bits), 64'd0);
        check("rst_rd_en", 64'(io_sp_read_en), 64'd0);
        check("rst_rd_addr", 64'(io_sp_read_addr), 64'd0);

        // Three-symbol table: A=0, B=10, C=11.
        mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43; mem[3] = 8'h41; mem[16'h0010] = 8'h58;
        wr_table(1'b0, 8'h41, 64'h0000_0000_0001_0000);
        wr_table(1'b0, 8'h42, 64'h0000_0000_0002_0002);
        wr_table(1'b0, 8'h43, 64'h0000_0000_0002_0003);
        wr_table(1'b1, 8'd0, 64'h0000_0000_0043_4241);
        wr_table(1'b1, 8'd32, 64'h0000_0000_0001_0000);
        wr_table(1'b1, 8'd33, 64'h0000_0001_0002_0002);
        run_abc("abc");

        for (int e = 0; e < 2; e++) begin
            rc0 = rd_count; rs0 = resp_count;
            request(e[0], 16'h0000, 0);
            wait_done(e[0] ? "len0_enc" : "len0_dec", 10, n);
            check("len0_latency_ok", 64'(n <= 2), 64'd1);
            check("len0_reads", 64'(rd_count - rc0), 64'd0);
            check("len0_resps", 64'(resp_count - rs0), 64'd0);
        end

        wr_csr(2'd0, 11'd0); wr_csr(2'd1, 11'd1024); wr_csr(2'd2, 11'd1536); wr_csr(2'd3, 11'd0);
        wr_csr(2'd0, 11'd256);
        run_abc("csr");

        // Canonical table: 4 symbols of length 4, 132 of length 8, 120 of length 9.
        for (int r = 0; r < 256; r++) begin
            rsym[r] = 8'(r * 37 + 11);
            rlen[r] = r < 4 ? 4 : r < 136 ? 8 : 9;
        end
        code = 0; rank = 0;
        for (int l = 1; l <= 16; l++) begin
            n = 0;
            for (int r = 0; r < 256; r++) if (rlen[r] == l) begin
                tcode[rsym[r]] = 16'(code + n);
                tlen[rsym[r]] = l;
                n++;
            end
            wr_table(1'b1, 8'(31 + l), (64'(rank) << 32) | (64'(n) << 16) | 64'(code & 16'hffff));
            code = (code + n) << 1;
            rank += n;
        end
        for (int s = 0; s < 256; s++) wr_table(1'b0, 8'(s), (64'(tlen[s]) << 16) | 64'(tcode[s]));
        for (int w = 0; w < 32; w++) begin
            for (int i = 0; i < 8; i++) wd[8*i +: 8] = rsym[8*w+i];
            wr_table(1'b1, 8'(w), wd);
        end

        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom_range(0, 255));
            src[i] = x;
            mem[16'(16'h0100 + i)] = x;
            for (int b = tlen[x] - 1; b >= 0; b--) bits.push_back(tcode[x][b]);
        end
        while (bits.size() % 8 != 0) bits.push_back(1'b0);
        for (int i = 0; i < bits.size(); i += 8) begin
            for (int k = 0; k < 8; k++) by[7-k] = bits[i+k];
            enc.push_back(by);
        end

        foreach (enc[i]) exp_q.push_back(enc[i]);
        rs0 = resp_count;
        request(1'b1, 16'h0100, 1000);
        wait_done("rt_enc", 5000, n);
        check("rt_enc_bytes", 64'(resp_count - rs0), 64'(enc.size()));
        check("rt_enc_drained", 64'(exp_q.size()), 64'd0);

        foreach (enc[i]) mem[16'(16'h4000 + i)] = enc[i];
        for (int i = 0; i < 1000; i++) exp_q.push_back(src[i]);
        rs0 = resp_count;
        request(1'b0, 16'h4000, 1000);
        wait_done("rt_dec", 15000, n);
        check("rt_dec_symbols", 64'(resp_count - rs0), 64'd1000);
        check("rt_dec_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of a long encode.
        foreach (enc[i]) exp_q.push_back(enc[i]);
        request(1'b1, 16'h0100, 1000);
        repeat (40) @(negedge clock);
        check("mid_busy", 64'(io_req_ready), 64'd0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ready", 64'(io_req_ready), 64'd1);
        check("mid_rst_valid", 64'(io_resp_valid), 64'd0);
        check("mid_rst_bits", 64'(io_resp_bits), 64'd0);
        check("mid_rst_rd_en", 64'(io_sp_read_en), 64'd0);
        check("mid_rst_rd_addr", 64'(io_sp_read_addr), 64'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        rc0 = rd_count; rs0 = resp_count;
        repeat (20) @(negedge clock);
        check("post_rst_ready", 64'(io_req_ready), 64'd1);
        check("post_rst_reads", 64'(rd_count - rc0), 64'd0);
        check("post_rst_resps", 64'(resp_count - rs0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
